// File: rtl/reg_file_pkg.sv
// Shared integer-register-file constants for the datapath stages.
// Width, register count and address width are defined once here.
package reg_file_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// Integer register file: x0 hardwired to zero, two combinational read ports,
// one write port gated by write enable and pipeline stall, synchronous reset.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int XLEN = reg_file_pkg::XLEN,
    parameter int NREG = reg_file_pkg::NREG
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            we,
    input  logic            stall,
    output logic [XLEN-1:0] rs1d,
    output logic [XLEN-1:0] rs2d
);

    logic [XLEN-1:0] regs_r [0:NREG-1];
    logic            wr_en_s;
    logic [XLEN-1:0] rs1d_s;
    logic [XLEN-1:0] rs2d_s;

    // Write qualification: x0 and out-of-range addresses are never written.
    always_comb begin
        wr_en_s = 1'b0;
        if (we && !stall && (rd != ZERO_REG) && (32'(rd) < NREG)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Register storage; reset wins over any write on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[rd] <= wb_data;
        end
    end

    // Read port 1: no bypass from the write port, old value until the edge.
    always_comb begin
        rs1d_s = {XLEN{1'b0}};
        if ((rs1 == ZERO_REG) || (32'(rs1) >= NREG)) begin
            rs1d_s = {XLEN{1'b0}};
        end else begin
            rs1d_s = regs_r[rs1];
        end
    end

    // Read port 2: independent mux, identical decode to port 1.
    always_comb begin
        rs2d_s = {XLEN{1'b0}};
        if ((rs2 == ZERO_REG) || (32'(rs2) >= NREG)) begin
            rs2d_s = {XLEN{1'b0}};
        end else begin
            rs2d_s = regs_r[rs2];
        end
    end

    assign rs1d = rs1d_s;
    assign rs2d = rs2d_s;

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, write/read timing,
// x0, stall, we gating, dual reads and reset priority.
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic        we;
    logic        stall;
    logic [31:0] rs1d;
    logic [31:0] rs2d;

    int n_checks;
    int n_fail;

    reg_file dut (
        .clk     (clk),
        .reset   (reset),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd      (rd),
        .wb_data (wb_data),
        .we      (we),
        .stall   (stall),
        .rs1d    (rs1d),
        .rs2d    (rs2d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        rd = addr; wb_data = data; we = 1'b1; stall = 1'b0;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            n_checks++;
            if (rs1d !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rs1[%0d]: got %h expected %h", i, rs1d, 32'h0);
            end
            n_checks++;
            if (rs2d !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rs2[%0d]: got %h expected %h", 31 - i, rs2d, 32'h0);
            end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        rd = 5'd1; wb_data = 32'h5555_5555; we = 1'b1; stall = 1'b0;
        rs1 = 5'd1; rs2 = 5'd1;
        #1;
        n_checks++;
        if (rs1d !== 32'h0) begin
            n_fail++;
            $display("FAIL pre_edge_rs1: got %h expected %h", rs1d, 32'h0);
        end
        n_checks++;
        if (rs2d !== 32'h0) begin
            n_fail++;
            $display("FAIL pre_edge_rs2: got %h expected %h", rs2d, 32'h0);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rs1d !== 32'h5555_5555) begin
            n_fail++;
            $display("FAIL post_edge_rs1: got %h expected %h", rs1d, 32'h5555_5555);
        end
        n_checks++;
        if (rs2d !== 32'h5555_5555) begin
            n_fail++;
            $display("FAIL post_edge_rs2: got %h expected %h", rs2d, 32'h5555_5555);
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_x0();
        write_reg(5'd0, 32'hFFFF_FFFF);
        rs1 = 5'd0; rs2 = 5'd0;
        #1;
        n_checks++;
        if (rs1d !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_rs1: got %h expected %h", rs1d, 32'h0);
        end
        n_checks++;
        if (rs2d !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_rs2: got %h expected %h", rs2d, 32'h0);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        rd = 5'd5; wb_data = 32'hDEAD_BEEF; we = 1'b1; stall = 1'b1;
        rs1 = 5'd5; rs2 = 5'd1;
        @(posedge clk);
        #1;
        n_checks++;
        if (rs1d !== 32'h0) begin
            n_fail++;
            $display("FAIL stall_blocks_write: got %h expected %h", rs1d, 32'h0);
        end
        n_checks++;
        if (rs2d !== 32'h5555_5555) begin
            n_fail++;
            $display("FAIL stall_read_live: got %h expected %h", rs2d, 32'h5555_5555);
        end
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (rs1d !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL unstall_write: got %h expected %h", rs1d, 32'hDEAD_BEEF);
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_we_low();
        @(negedge clk);
        rd = 5'd1; wb_data = 32'h0000_0000; we = 1'b0; stall = 1'b0;
        rs1 = 5'd1;
        @(posedge clk);
        #1;
        n_checks++;
        if (rs1d !== 32'h5555_5555) begin
            n_fail++;
            $display("FAIL we_low_hold: got %h expected %h", rs1d, 32'h5555_5555);
        end
    endtask

    task automatic test_dual_read();
        write_reg(5'd3, 32'h1234_5678);
        write_reg(5'd4, 32'hCAFE_BABE);
        rs1 = 5'd3; rs2 = 5'd4;
        #1;
        n_checks++;
        if (rs1d !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL dual_rs1_x3: got %h expected %h", rs1d, 32'h1234_5678);
        end
        n_checks++;
        if (rs2d !== 32'hCAFE_BABE) begin
            n_fail++;
            $display("FAIL dual_rs2_x4: got %h expected %h", rs2d, 32'hCAFE_BABE);
        end
        rs1 = 5'd4; rs2 = 5'd3;
        #1;
        n_checks++;
        if (rs1d !== 32'hCAFE_BABE) begin
            n_fail++;
            $display("FAIL swap_rs1_x4: got %h expected %h", rs1d, 32'hCAFE_BABE);
        end
        n_checks++;
        if (rs2d !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL swap_rs2_x3: got %h expected %h", rs2d, 32'h1234_5678);
        end
        rs1 = 5'd5; rs2 = 5'd5;
        #1;
        n_checks++;
        if ((rs1d !== 32'hDEAD_BEEF) || (rs2d !== 32'hDEAD_BEEF)) begin
            n_fail++;
            $display("FAIL same_addr_x5: got %h/%h expected %h", rs1d, rs2d, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        reset = 1'b1; we = 1'b1; stall = 1'b0; rd = 5'd7; wb_data = 32'hAAAA_AAAA;
        @(negedge clk);
        reset = 1'b0; we = 1'b0;
        rs1 = 5'd7; rs2 = 5'd5;
        #1;
        n_checks++;
        if (rs1d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_priority_x7: got %h expected %h", rs1d, 32'h0);
        end
        n_checks++;
        if (rs2d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_clears_x5: got %h expected %h", rs2d, 32'h0);
        end
        rs1 = 5'd3; rs2 = 5'd1;
        #1;
        n_checks++;
        if ((rs1d !== 32'h0) || (rs2d !== 32'h0)) begin
            n_fail++;
            $display("FAIL reset_clears_x3_x1: got %h/%h expected %h", rs1d, rs2d, 32'h0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; we = 1'b0; stall = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; wb_data = 32'h0;
        test_reset();
        test_write_read();
        test_x0();
        test_stall();
        test_we_low();
        test_dual_read();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file
